ext_fifo_tx_arbiter: RTL and testbench

//  Shares the transceiver's single TX AXI-Stream input (s_axis_*) among NUM_SRC packet sources.

---
 rtl/ext_fifo_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ext_fifo_tx_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_fifo_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the transceiver's single TX AXI-Stream input.
// Grant holds until tlast; overlong packets are cut at MAX_BEATS, flagged via tuser, and their tail drained.
module ext_fifo_tx_arbiter #(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BEATS = 1536
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC*DATA_W-1:0]   s_tdata,
    input  logic [NUM_SRC*8-1:0]        s_tid,
    input  logic [NUM_SRC*8-1:0]        s_tdest,
    input  logic [NUM_SRC-1:0]          s_tkeep,
    input  logic [NUM_SRC-1:0]          s_tuser,
    input  logic [NUM_SRC-1:0]          s_tlast,
    input  logic [NUM_SRC-1:0]          s_tvalid,
    output logic [NUM_SRC-1:0]          s_tready,
    output logic [DATA_W-1:0]           m_axis_tdata,
    output logic [7:0]                  m_axis_tid,
    output logic [7:0]                  m_axis_tdest,
    output logic                        m_axis_tkeep,
    output logic                        m_axis_tuser,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [NUM_SRC-1:0]          grant,
    output logic [15:0]                 trunc_cnt
);

    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [NUM_SRC-1:0] grant_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [IDX_W-1:0]   last_ptr, last_nxt;
    logic [CNT_W-1:0]   beat_cnt, beat_nxt;
    logic [15:0]        trunc_nxt;

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               beat;

    logic [DATA_W-1:0]  src_data  [NUM_SRC];
    logic [7:0]         src_tid   [NUM_SRC];
    logic [7:0]         src_tdest [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_data[i]  = s_tdata[i*DATA_W +: DATA_W];
        assign src_tid[i]   = s_tid[i*8 +: 8];
        assign src_tdest[i] = s_tdest[i*8 +: 8];
    end

    // First valid requester strictly after the last-served source, wrapping around
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            if (!sel_found && s_tvalid[IDX_W'((32'(last_ptr) + k) % NUM_SRC)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'((32'(last_ptr) + k) % NUM_SRC);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            owner     <= '0;
            last_ptr  <= IDX_W'(NUM_SRC - 1);
            beat_cnt  <= '0;
            trunc_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            owner     <= owner_nxt;
            last_ptr  <= last_nxt;
            beat_cnt  <= beat_nxt;
            trunc_cnt <= trunc_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        owner_nxt     = owner;
        last_nxt      = last_ptr;
        beat_nxt      = beat_cnt;
        trunc_nxt     = trunc_cnt;
        beat          = 1'b0;
        s_tready      = '0;
        m_axis_tdata  = '0;
        m_axis_tid    = '0;
        m_axis_tdest  = '0;
        m_axis_tkeep  = 1'b0;
        m_axis_tuser  = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tvalid = 1'b0;

        unique case (state)
            IDLE: begin
                if (sel_found) begin
                    grant_nxt = NUM_SRC'(1) << sel_idx;
                    owner_nxt = sel_idx;
                    state_nxt = PASS;
                end
            end

            PASS: begin
                m_axis_tdata  = src_data[owner];
                m_axis_tid    = src_tid[owner];
                m_axis_tdest  = src_tdest[owner];
                m_axis_tkeep  = s_tkeep[owner];
                m_axis_tuser  = s_tuser[owner];
                m_axis_tlast  = s_tlast[owner];
                m_axis_tvalid = s_tvalid[owner];
                s_tready      = grant & {NUM_SRC{m_axis_tready}};
                beat          = s_tvalid[owner] & m_axis_tready;
                if (beat) begin
                    if (s_tlast[owner]) begin
                        beat_nxt  = '0;
                        last_nxt  = owner;
                        grant_nxt = '0;
                        state_nxt = IDLE;
                    end else if (beat_cnt == CNT_W'(MAX_BEATS - 1)) begin
                        // Cap reached without tlast: terminate downstream and flag it
                        m_axis_tlast = 1'b1;
                        m_axis_tuser = 1'b1;
                        beat_nxt     = '0;
                        if (trunc_cnt != 16'hFFFF) begin
                            trunc_nxt = trunc_cnt + 16'd1;
                        end
                        state_nxt = DRAIN;
                    end else begin
                        beat_nxt = beat_cnt + CNT_W'(1);
                    end
                end
            end

            DRAIN: begin
                s_tready = grant;
                if (s_tvalid[owner] && s_tlast[owner]) begin
                    last_nxt  = owner;
                    grant_nxt = '0;
                    state_nxt = IDLE;
                end
            end

            default: begin
                grant_nxt = '0;
                beat_nxt  = '0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ext_fifo_tx_arbiter.sv
// Scoreboard bench for ext_fifo_tx_arbiter: queue-backed sources, expected beats in arbitration order,
// a negedge monitor compares every forwarded beat plus tready mirroring and stall stability.
module tb_ext_fifo_tx_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned MB = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct packed {
        logic [3:0] grant;
        logic [7:0] data;
        logic [7:0] tid;
        logic [7:0] tdest;
        logic       keep;
        logic       last;
        logic       user;
    } obs_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*DW-1:0]   s_tdata;
    logic [N*8-1:0]    s_tid;
    logic [N*8-1:0]    s_tdest;
    logic [N-1:0]      s_tkeep;
    logic [N-1:0]      s_tuser;
    logic [N-1:0]      s_tlast;
    logic [N-1:0]      s_tvalid;
    logic [N-1:0]      s_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [7:0]        m_axis_tid;
    logic [7:0]        m_axis_tdest;
    logic              m_axis_tkeep;
    logic              m_axis_tuser;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [N-1:0]      grant;
    logic [15:0]       trunc_cnt;

    beat_t src_q [N][$];
    obs_t  exp_q [$];
    int    total = 0;
    int    bad   = 0;

    logic       noise_en = 1'b0;
    logic [3:0] noise    = '0;
    int         tmode    = 0;

    always #5 clk = ~clk;

    ext_fifo_tx_arbiter #(.NUM_SRC(N), .DATA_W(DW), .MAX_BEATS(MB)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tid(s_tid), .s_tdest(s_tdest), .s_tkeep(s_tkeep),
        .s_tuser(s_tuser), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .grant(grant), .trunc_cnt(trunc_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Source models: pop on handshake, present the next queued beat 1ns after the edge
    initial begin
        logic [N-1:0] fire;
        s_tdata = '0; s_tid = '0; s_tdest = '0; s_tkeep = '0;
        s_tuser = '0; s_tlast = '0; s_tvalid = '0; m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            fire = s_tvalid & s_tready;
            #1;
            for (int i = 0; i < N; i++) begin
                if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    s_tvalid[i]          = 1'b1;
                    s_tdata[i*DW +: DW]  = src_q[i][0].data;
                    s_tlast[i]           = src_q[i][0].last;
                    s_tuser[i]           = src_q[i][0].user;
                end else begin
                    s_tvalid[i]          = 1'b0;
                    s_tdata[i*DW +: DW]  = '0;
                    s_tlast[i]           = 1'b0;
                    s_tuser[i]           = 1'b0;
                end
                s_tkeep[i]      = 1'b1;
                s_tid[i*8 +: 8]   = 8'(8'h10 + i);
                s_tdest[i*8 +: 8] = 8'(8'h20 + i);
            end
            if (noise_en) s_tvalid = noise;
            if (tmode == 1) m_axis_tready = ~m_axis_tready;
            else            m_axis_tready = 1'b1;
        end
    end

    // Monitor: compare each forwarded beat against the scoreboard
    obs_t       mon_act;
    obs_t       mon_exp;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (m_axis_tvalid) chk("tready_mirror", 64'(s_tready), 64'(grant & {N{m_axis_tready}}));
            if (prev_stall && m_axis_tvalid) chk("stall_hold", 64'(m_axis_tdata), 64'(prev_data));
            if (m_axis_tvalid && m_axis_tready) begin
                mon_act = '{grant: grant, data: m_axis_tdata, tid: m_axis_tid, tdest: m_axis_tdest,
                            keep: m_axis_tkeep, last: m_axis_tlast, user: m_axis_tuser};
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h expected none", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("beat", 64'(mon_act), 64'(mon_exp));
                end
            end
            prev_stall = m_axis_tvalid & ~m_axis_tready;
            prev_data  = m_axis_tdata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // Queue a packet on source s and the beats expected downstream (truncated at MB)
    task automatic push_pkt(input int s, input logic [7:0] base, input int n);
        int nout;
        nout = (n > int'(MB)) ? int'(MB) : n;
        for (int i = 0; i < n; i++)
            src_q[s].push_back('{data: 8'(base + i), last: (i == n - 1), user: 1'b0});
        for (int i = 0; i < nout; i++)
            exp_q.push_back('{grant: 4'(1 << s), data: 8'(base + i), tid: 8'(8'h10 + s),
                              tdest: 8'(8'h20 + s), keep: 1'b1,
                              last: (i == nout - 1), user: (n > int'(MB)) && (i == nout - 1)});
    endtask

    task automatic wait_empty(input string name, input int budget, output int k);
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        noise_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            noise = 4'($urandom);
        end
        tick();
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_tready", 64'(s_tready), 64'd0);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_trunc", 64'(trunc_cnt), 64'd0);
        noise_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single source, 4 beats A0..A3
        push_pkt(2, 8'hA0, 4);
        tick();
        chk("t2_grant_pre", 64'(grant), 64'd0);
        tick();
        chk("t2_grant", 64'(grant), 64'b0100);
        wait_empty("t2", 20, k);
        chk("t2_cycles", 64'(k), 64'd4);
        chk("t2_grant_idle", 64'(grant), 64'd0);

        // Round-robin from reset: order 0,1,2,3,0,1,2,3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 4; s++)
                push_pkt(s, 8'((s << 4) | (p << 2)), 2);
        wait_empty("t3", 80, k);
        tick();

        // Backpressure: tready toggles every cycle
        tmode = 1;
        push_pkt(3, 8'hC0, 3);
        wait_empty("t4", 40, k);
        tmode = 0;
        tick();
        tick();

        // Truncation: src1 12 beats cut at 8, then src0 served
        push_pkt(0, 8'h50, 2);
        wait_empty("t5a", 20, k);
        tick();
        push_pkt(1, 8'h60, 12);
        push_pkt(0, 8'h70, 2);
        wait_empty("t5", 60, k);
        tick();
        chk("t5_trunc_cnt", 64'(trunc_cnt), 64'd1);
        chk("t5_src1_drained", 64'(src_q[1].size()), 64'd0);

        // Exactly MB beats with tlast: normal end
        push_pkt(2, 8'h80, 8);
        wait_empty("t6", 40, k);
        tick();
        chk("t6_trunc_cnt", 64'(trunc_cnt), 64'd1);

        // Reset mid-packet
        push_pkt(3, 8'h90, 6);
        k = 0;
        while (exp_q.size() > 3 && k < 40) begin
            tick();
            k++;
        end
        chk("t6r_progress", 64'(exp_q.size() <= 3), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6r_grant_async", 64'(grant), 64'd0);
        chk("t6r_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("t6r_tready", 64'(s_tready), 64'd0);
        exp_q.delete();
        src_q[3].delete();
        tick();
        chk("t6r_grant_edge", 64'(grant), 64'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("t6r_grant_idle", 64'(grant), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
